// File: rtl/sonar_pkg.sv
// Shared types and default constants for the sonar-to-pitch path.
// Optional smoothing is enabled with the SONAR_AVG_EN macro.
package sonar_pkg;

  localparam int DIST_W_DEF      = 9;
  localparam int BASE_TW_DEF     = 10000;
  localparam int STEP_TW_DEF     = 2000;
  localparam int TIMEOUT_CYC_DEF = 10000000;

  typedef logic [DIST_W_DEF-1:0] dist_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GLIDE
  } state_t;

endpackage

// File: rtl/glide_ramp.sv
// Tick divider plus bounded step of a value toward its target.
// Snap loads the target directly and always reports a change.
module glide_ramp
  import sonar_pkg::*;
#(
  parameter int TW_W       = 32,
  parameter int GLIDE_STEP = 64,
  parameter int GLIDE_DIV  = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TW_W-1:0] target,
  input  logic            load_snap,
  input  logic            glide_en,
  output logic [TW_W-1:0] value,
  output logic            changed,
  output logic            at_target
);

  localparam int DIV_W =
    (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TOP =
    DIV_W'(GLIDE_DIV - 1);
  localparam logic [TW_W-1:0] STEP_MAX =
    TW_W'(GLIDE_STEP);

  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic             up;
  logic [TW_W-1:0]  diff;
  logic [TW_W-1:0]  step;

  assign tick      = (div_q == DIV_TOP);
  assign at_target = (value == target);
  assign up        = (target > value);
  assign diff      = up ? (target - value)
                        : (value - target);
  assign step      = (diff > STEP_MAX) ? STEP_MAX
                                       : diff;

  // Free-running glide tick divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Current value: snap load or one bounded step per tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      value   <= '0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (load_snap) begin
        value   <= target;
        changed <= 1'b1;
      end else if (glide_en && tick && !at_target) begin
        value   <= up ? (value + step)
                      : (value - step);
        changed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sonar_pitch_mapper.sv
// Sonar distance to DDS tuning word with glide and echo-loss mute.
// Define SONAR_AVG_EN to add moving-average smoothing of samples.
module sonar_pitch_mapper
  import sonar_pkg::*;
#(
  parameter int DIST_W      = DIST_W_DEF,
  parameter int TW_W        = 32,
  parameter int BASE_TW     = BASE_TW_DEF,
  parameter int STEP_TW     = STEP_TW_DEF,
  parameter int DIST_MIN    = 2,
  parameter int DIST_MAX    = 120,
  parameter int GLIDE_STEP  = 64,
  parameter int GLIDE_DIV   = 1000,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`ifdef SONAR_AVG_EN
  ,parameter int AVG_LOG2   = 2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIST_W-1:0] distance_in,
  input  logic              valid_in,
  output logic [TW_W-1:0]   tuning_word,
  output logic              gate,
  output logic              tw_valid,
  output logic              in_range
);

  localparam int PW   = TW_W + DIST_W;
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_TOP =
    TO_W'(TIMEOUT_CYC - 1);
  localparam logic [DIST_W-1:0] LO = DIST_W'(DIST_MIN);
  localparam logic [DIST_W-1:0] HI = DIST_W'(DIST_MAX);

  state_t            state;
  logic [TO_W-1:0]   to_cnt;
  logic              in_win;
  logic              accept;
  logic              expire;
  logic              acc_v;
  logic              tgt_v;
  logic [DIST_W-1:0] d_eff;
  logic [PW-1:0]     prod;
  logic [TW_W-1:0]   target_r;
  logic              load_snap;
  logic              glide_en;
  logic              at_target;

  assign in_win = (distance_in >= LO) &&
                  (distance_in <= HI);
  assign accept = valid_in && in_win;
  assign expire = (state != IDLE) &&
                  (to_cnt == TO_TOP) && !accept;

  // Accept stage: window check and range flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_range <= 1'b0;
      acc_v    <= 1'b0;
    end else begin
      acc_v <= accept;
      if (valid_in) begin
        in_range <= in_win;
      end
    end
  end

`ifdef SONAR_AVG_EN
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = DIST_W + AVG_LOG2;

  logic [DIST_W-1:0]   avg_buf [DEPTH];
  logic [SUM_W-1:0]    sum_q;
  logic [AVG_LOG2-1:0] ptr_q;
  logic                filled_q;

  // Circular buffer with running sum; first note prefills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        avg_buf[i] <= '0;
      end
      sum_q    <= '0;
      ptr_q    <= '0;
      filled_q <= 1'b0;
    end else if (expire) begin
      filled_q <= 1'b0;
    end else if (accept) begin
      if (!filled_q) begin
        for (int i = 0; i < DEPTH; i++) begin
          avg_buf[i] <= distance_in;
        end
        sum_q    <= SUM_W'(distance_in) << AVG_LOG2;
        ptr_q    <= AVG_LOG2'(1);
        filled_q <= 1'b1;
      end else begin
        avg_buf[ptr_q] <= distance_in;
        sum_q <= sum_q - SUM_W'(avg_buf[ptr_q])
                       + SUM_W'(distance_in);
        ptr_q <= ptr_q + 1'b1;
      end
    end
  end

  assign d_eff = sum_q[SUM_W-1:AVG_LOG2];
`else
  logic [DIST_W-1:0] acc_d;

  // Raw accepted sample register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_d <= '0;
    end else if (accept) begin
      acc_d <= distance_in;
    end
  end

  assign d_eff = acc_d;
`endif

  assign prod = PW'(BASE_TW) +
                PW'(d_eff) * PW'(STEP_TW);

  // Target stage: linear map, saturating to all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_r <= '0;
      tgt_v    <= 1'b0;
    end else begin
      tgt_v <= acc_v;
      if (acc_v) begin
        target_r <= (|prod[PW-1:TW_W]) ? '1
                                       : prod[TW_W-1:0];
      end
    end
  end

  assign load_snap = (state == IDLE) && tgt_v;
  assign glide_en  = (state == GLIDE) && !expire;

  glide_ramp #(
    .TW_W       (TW_W),
    .GLIDE_STEP (GLIDE_STEP),
    .GLIDE_DIV  (GLIDE_DIV)
  ) u_ramp (
    .clk       (clk),
    .rst       (rst),
    .target    (target_r),
    .load_snap (load_snap),
    .glide_en  (glide_en),
    .value     (tuning_word),
    .changed   (tw_valid),
    .at_target (at_target)
  );

  // Note FSM with echo-loss timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gate   <= 1'b0;
      to_cnt <= '0;
    end else if (expire) begin
      state  <= IDLE;
      gate   <= 1'b0;
      to_cnt <= '0;
    end else begin
      if (accept || state == IDLE) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (tgt_v) begin
            state <= HOLD;
            gate  <= 1'b1;
          end
        end
        HOLD: begin
          if (tgt_v && target_r != tuning_word) begin
            state <= GLIDE;
          end
        end
        GLIDE: begin
          if (at_target) begin
            state <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_pitch_mapper.sv
// Directed bench for sonar_pitch_mapper (GLIDE_DIV=4, TIMEOUT_CYC=100).
// Define SONAR_AVG_EN to run the smoothing sequence instead.
module tb_sonar_pitch_mapper;
  import sonar_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  dist_t       distance_in;
  logic        valid_in;
  logic [31:0] tuning_word;
  logic        gate;
  logic        tw_valid;
  logic        in_range;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sonar_pitch_mapper #(
    .DIST_W      (9),
    .TW_W        (32),
    .BASE_TW     (10000),
    .STEP_TW     (2000),
    .DIST_MIN    (2),
    .DIST_MAX    (120),
    .GLIDE_STEP  (64),
    .GLIDE_DIV   (4),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .distance_in (distance_in),
    .valid_in    (valid_in),
    .tuning_word (tuning_word),
    .gate        (gate),
    .tw_valid    (tw_valid),
    .in_range    (in_range)
  );

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  // Drive one sample; returns just after its accept edge.
  task automatic send(input int d);
    @(negedge clk);
    valid_in    = 1'b1;
    distance_in = dist_t'(d);
    @(negedge clk);
    valid_in    = 1'b0;
  endtask

  // Watch n cycles and require no tw_valid pulse.
  task automatic quiet(input int n, input string nm);
    int p;
    p = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tw_valid) p++;
    end
    check(nm, p, 0);
  endtask

  function automatic logic [31:0] toward(
      input logic [31:0] v, input logic [31:0] t);
    logic [31:0] d;
    d = (t > v) ? t - v : v - t;
    if (d > 32'd64) d = 32'd64;
    return (t > v) ? v + d : v - d;
  endfunction

  // Follow a glide pulse by pulse, sending keepalive samples.
  task automatic glide_watch(input logic [31:0] start,
                             input logic [31:0] tgt,
                             input int k0, input int k1,
                             input int k2, input int k3);
    logic [31:0] expv;
    int pulses, last, ka, kd;
    expv = start;
    pulses = 0;
    last = -1;
    ka = 0;
    for (int i = 0; i < 400 && expv != tgt; i++) begin
      @(negedge clk);
      if (tw_valid) begin
        expv = toward(expv, tgt);
        check("glide_tw", tuning_word, expv);
        if (last >= 0) check("glide_gap", i - last, 4);
        last = i;
        pulses++;
      end
      valid_in = (i % 30 == 29) && (expv != tgt);
      if (valid_in) begin
        case (ka % 4)
          0: kd = k0;
          1: kd = k1;
          2: kd = k2;
          default: kd = k3;
        endcase
        distance_in = dist_t'(kd);
        ka++;
      end
    end
    valid_in = 1'b0;
    check("glide_end", tuning_word, tgt);
    check("glide_ticks", pulses, 32);
  endtask

`ifdef SONAR_AVG_EN
  task automatic avg_test();
    send(10);
    repeat (2) @(negedge clk);
    check("avg_snap", tuning_word, 30000);
    check("avg_snap_pulse", tw_valid, 1);
    for (int k = 0; k < 2; k++) begin
      send(10);
      repeat (2) @(negedge clk);
      check("avg_same_tw", tuning_word, 30000);
      check("avg_same_pulse", tw_valid, 0);
    end
    send(14);
    glide_watch(32'd30000, 32'd32000, 10, 10, 10, 14);
    quiet(8, "avg_hold_quiet");
    check("avg_final", tuning_word, 32000);
  endtask
`else
  typedef struct {
    dist_t       d;
    logic        rng;
    logic [31:0] tw;
    logic        gt;
    logic        pulse;
  } vec_t;

  task automatic table_test();
    vec_t v [6];
    v[0] = '{d: 0,   rng: 0, tw: 0,      gt: 0, pulse: 0};
    v[1] = '{d: 1,   rng: 0, tw: 0,      gt: 0, pulse: 0};
    v[2] = '{d: 511, rng: 0, tw: 0,      gt: 0, pulse: 0};
    v[3] = '{d: 121, rng: 0, tw: 0,      gt: 0, pulse: 0};
    v[4] = '{d: 120, rng: 1, tw: 250000, gt: 1, pulse: 1};
    v[5] = '{d: 2,   rng: 1, tw: 250000, gt: 1, pulse: 0};
    for (int k = 0; k < 6; k++) begin
      send(int'(v[k].d));
      check($sformatf("tbl%0d_rng", k), in_range, v[k].rng);
      repeat (2) @(negedge clk);
      check($sformatf("tbl%0d_tw", k), tuning_word, v[k].tw);
      check($sformatf("tbl%0d_gate", k), gate, v[k].gt);
      check($sformatf("tbl%0d_pulse", k), tw_valid,
            v[k].pulse);
    end
    for (int i = 0; i < 12 && !tw_valid; i++) begin
      @(negedge clk);
    end
    check("down_step", tuning_word, 249936);
  endtask

  task automatic main_test();
    send(10);
    check("rng_10", in_range, 1);
    @(negedge clk);
    check("e2_tw", tuning_word, 0);
    check("e2_pulse", tw_valid, 0);
    @(negedge clk);
    check("snap_tw", tuning_word, 30000);
    check("snap_gate", gate, 1);
    check("snap_pulse", tw_valid, 1);
    @(negedge clk);
    check("pulse_one_cycle", tw_valid, 0);

    send(11);
    glide_watch(32'd30000, 32'd32000, 11, 11, 11, 11);
    quiet(6, "hold_quiet");

    send(11);
    send(200);
    check("rng_200", in_range, 0);
    check("tw_200", tuning_word, 32000);
    check("gate_200", gate, 1);
    quiet(97, "to_quiet");
    check("to_before_gate", gate, 1);
    @(negedge clk);
    check("to_gate", gate, 0);
    check("to_tw_held", tuning_word, 32000);
    check("to_pulse", tw_valid, 0);

    send(5);
    check("rng_5", in_range, 1);
    @(negedge clk);
    check("resnap_e2_tw", tuning_word, 32000);
    check("resnap_e2_gate", gate, 0);
    @(negedge clk);
    check("resnap_tw", tuning_word, 20000);
    check("resnap_gate", gate, 1);
    check("resnap_pulse", tw_valid, 1);

    send(5);
    repeat (99) @(negedge clk);
    valid_in    = 1'b1;
    distance_in = dist_t'(5);
    @(negedge clk);
    valid_in    = 1'b0;
    check("expiry_race_gate", gate, 1);
    quiet(10, "expiry_race_quiet");
    check("expiry_race_later", gate, 1);

    send(20);
    repeat (20) @(negedge clk);
    check("midglide_moving",
          tuning_word > 32'd20000, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_tw", tuning_word, 0);
    check("mrst_gate", gate, 0);
    check("mrst_pulse", tw_valid, 0);
    check("mrst_rng", in_range, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("mrst_flush_tw", tuning_word, 0);
    check("mrst_flush_gate", gate, 0);
  endtask
`endif

  initial begin
    rst         = 1'b1;
    valid_in    = 1'b0;
    distance_in = '0;
    repeat (3) @(negedge clk);
    check("rst_tw", tuning_word, 0);
    check("rst_gate", gate, 0);
    check("rst_pulse", tw_valid, 0);
    check("rst_rng", in_range, 0);
    rst = 1'b0;
`ifdef SONAR_AVG_EN
    avg_test();
`else
    main_test();
    table_test();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
